// File: rtl/seg_bcd_feeder.sv
// seg_bcd_feeder: sequential binary-to-BCD converter (shift-and-add-3)
// feeding eight seven-segment patterns with leading-zero blanking.
module seg_bcd_feeder #(
   parameter int WIDTH  = 27,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_value,
   input  logic                  blank_lz,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  overflow
);

   localparam int BW   = 4 * DIGITS;
   localparam int CW   = (WIDTH > BW) ? WIDTH : BW;
   localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // 10^DIGITS - 1; always fits in 4*DIGITS bits since 10 < 16.
   function automatic logic [CW-1:0] max_value();
      logic [CW-1:0] p;
      p = CW'(1);
      for (int i = 0; i < DIGITS; i++) begin
         p = p * CW'(10);
      end
      return p - CW'(1);
   endfunction

   localparam logic [CW-1:0] MAX_VALUE = max_value();

   // Segment pattern for one BCD nibble, bit 6 = a ... bit 0 = g.
   function automatic logic [6:0] seg_map(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   state_t state;
   state_t state_n;

   logic [WIDTH-1:0] bin_q;
   logic [BW-1:0]    acc_q;
   logic [BW-1:0]    acc_adj;
   logic [CNTW-1:0]  cnt_q;
   logic             lz_q;
   logic             ovf_q;
   logic             load;
   logic [CW-1:0]    in_ext;
   logic [7*DIGITS-1:0] seg_n;

   assign in_ext = CW'(in_value);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic and handshake.
   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      load     = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == '0) begin
               state_n = COMMIT;
            end
         end
         COMMIT: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Add 3 to every accumulator nibble that is 5 or more.
   always_comb begin
      acc_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end else begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4];
         end
      end
   end

   // Segment patterns with optional leading-zero blanking; digit 0 always lit.
   always_comb begin : seg_build
      logic       lead;
      logic [3:0] nib;
      seg_n = '0;
      lead  = 1'b1;
      nib   = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib = acc_q[4*i +: 4];
         if (nib != 4'd0) begin
            lead = 1'b0;
         end
         if (lz_q && lead && (i != 0)) begin
            seg_n[7*i +: 7] = 7'b0000000;
         end else begin
            seg_n[7*i +: 7] = seg_map(nib);
         end
      end
   end

   // Conversion datapath: load on accept, one shift per SHIFT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         lz_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (load) begin
         bin_q <= in_value;
         acc_q <= '0;
         cnt_q <= CNTW'(WIDTH - 1);
         lz_q  <= blank_lz;
         ovf_q <= (in_ext > MAX_VALUE);
      end else if (state == SHIFT) begin
         bin_q <= bin_q << 1;
         acc_q <= {acc_adj[BW-2:0], bin_q[WIDTH-1]};
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   // Output registers, updated only on commit and held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         bcd       <= '0;
         seg       <= '0;
         overflow  <= 1'b0;
      end else begin
         out_valid <= (state == COMMIT);
         if (state == COMMIT) begin
            if (ovf_q) begin
               bcd      <= '0;
               seg      <= {DIGITS{7'b0000001}};
               overflow <= 1'b1;
            end else begin
               bcd      <= acc_q;
               seg      <= seg_n;
               overflow <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/seg_bcd_feeder.md
# seg_bcd_feeder

Converts a binary value into eight BCD digits and their seven-segment patterns for the multiplexed seven-segment scanner that drives the display. The conversion is sequential (shift-and-add-3, one bit per cycle) behind a valid/ready handshake. The block holds the last converted result stable between updates, so the scanner can sample any digit at any time.

## Interface
- `WIDTH`, default 27: binary input width. Must be ≥ 1.
- `DIGITS`, default 8: number of output digits, matching the scanner's 8 positions.
- `clk`  in  1  system clock. All state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  `in_value` is offered.
- `in_ready`  out  1  block can accept a value.
- `in_value`  in  WIDTH  unsigned binary value.
- `blank_lz`  in  1  blank leading zeros. Sampled together with `in_value`.
- `out_valid`  out  1  one-cycle pulse, high in the cycle `bcd`/`seg` first show a new result.
- `bcd`  out  4*DIGITS  BCD digits. Digit 0 (least significant) is `bcd[3:0]`.
- `seg`  out  7*DIGITS  segment patterns, active-high. Digit i is `seg[7i+6:7i]`, bit 6 = a … bit 0 = g. Digit i drives scanner position i.
- `overflow`  out  1  last accepted value exceeded 10^DIGITS − 1.

## Operation
- Reset values:
  - `in_ready` = 1
  - `out_valid` = 0
  - `bcd` = 0
  - `seg` = 0 (all digits dark)
  - `overflow` = 0
  - FSM in IDLE
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch `in_value` into the shift register and latch `blank_lz`.
  - Compute the overflow flag: (`in_value` > 10^DIGITS − 1).
  - Clear the BCD accumulator and set the bit counter to WIDTH−1. Go to SHIFT.
- SHIFT, one iteration per cycle:
  - Add 3 to every accumulator nibble ≥ 5.
  - Then shift {accumulator, binary} left by 1.
  - After WIDTH iterations (counter reaches 0), go to COMMIT.
  - `in_ready` = 0. `in_valid` is ignored.
- COMMIT, one cycle:
  - Register the outputs: `bcd`, `seg`, `overflow`.
  - Assert `out_valid` in the following cycle.
  - Return to IDLE.
- Segment map: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Any other nibble = 0000000.
- Leading-zero blanking (when the latched `blank_lz` = 1):
  - Every digit above the most significant non-zero digit gets `seg` = 0000000.
  - Digit 0 is never blanked, so value 0 shows "0".
  - `bcd` is never blanked.
- Overflow:
  - `bcd` = all 0.
  - Every digit's `seg` = 0000001 (dash).
  - `overflow` = 1.
  - Blanking does not apply.
- Accumulator width: 4*DIGITS bits. Bits shifted out of the top are discarded; that case is covered by the overflow path.
- Outputs hold their values between commits. The rest of the design reads `seg` continuously.

## Timing
- Accept at edge T (handshake high in the cycle before T).
- SHIFT iterations occupy the cycles ending at edges T+1 … T+WIDTH.
- Outputs update at edge T+WIDTH+1, with `out_valid` high in the cycle after that edge.
- Latency: WIDTH+1 cycles from acceptance to new outputs (28 for the default).
- Throughput: one value per WIDTH+2 cycles.
- `in_ready` returns high in the same cycle `out_valid` pulses, so back-to-back acceptance is possible.
- Asserting `rst` mid-conversion immediately restores all reset values. The partial result is discarded and there is no `out_valid`.
- `in_value`/`blank_lz` changes after acceptance have no effect on the current conversion.

## Test plan
- Reset, then check idle state → `seg` = 0, `bcd` = 0, `in_ready` = 1, `out_valid` = 0, `overflow` = 0. All of these hold while `in_valid` = 0.
- Accept 12345678 with `blank_lz` = 0 → after 28 cycles `bcd` = 0x12345678, `seg[6:0]` = 1111111 ("8"), `seg[55:49]` = 0110000 ("1"). `out_valid` pulses exactly 1 cycle and `in_ready` is low for 28 cycles.
- Accept 0 and then 907, both with `blank_lz` = 1:
  - For 0 → digit 0 `seg` = 1111110 and digits 1–7 = 0.
  - For 907 → digits 3–7 are dark and digit 1 `seg` = 1111110 (inner zero kept).
- Accept 100000000 → `overflow` = 1, every `seg` digit = 0000001, `bcd` = 0. A following accept of 5 clears `overflow`.
- Drive `in_valid` continuously with alternating 99999999 and 1 → accepts are spaced 29 cycles apart and each result matches its input. Input changes during SHIFT are ignored.
- Assert `rst` 10 cycles into converting 4321 → all outputs return to their reset values immediately, with no `out_valid`. The next conversion after reset completes correctly.
